// File: rtl/fir_stim_pkg.sv
// Shared encodings for the FIR stimulus generator: waveform modes, FSM states and noise LFSR taps.
package fir_stim_pkg;
    localparam logic [2:0] MODE_DC      = 3'd0;
    localparam logic [2:0] MODE_IMPULSE = 3'd1;
    localparam logic [2:0] MODE_STEP    = 3'd2;
    localparam logic [2:0] MODE_ALT     = 3'd3;
    localparam logic [2:0] MODE_NOISE   = 3'd4;
    localparam logic [2:0] MODE_RAMP    = 3'd5;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;
endpackage

// File: rtl/fir_stim_lfsr.sv
// 16-bit right-shifting Galois LFSR; load returns to SEED, advance steps once; state_nxt is the look-ahead value.
module fir_stim_lfsr
    import fir_stim_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        advance,
    output logic [15:0] state,
    output logic [15:0] state_nxt
);
    assign state_nxt = (state >> 1) ^ (state[0] ? LFSR_TAPS : 16'h0000);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         state <= SEED;
        else if (load)    state <= SEED;
        else if (advance) state <= state_nxt;
    end
endmodule

// File: rtl/fir_stim_gen.sv
// Waveform stimulus generator for fir_filter: first data_valid 1 cycle after start, data held until data_ready.
// Optional sticky overflow monitor on the filter output when FIR_STIM_OVF_MON_EN is defined.
module fir_stim_gen
    import fir_stim_pkg::*;
#(
    parameter int          DATA_WIDTH = 16,
    parameter int          LEN_WIDTH  = 16,
    parameter int          DIV_WIDTH  = 16,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
`ifdef FIR_STIM_OVF_MON_EN
   ,parameter int          MON_WIDTH  = 32,
    parameter int          MON_GUARD  = 1
`endif
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic [2:0]                   mode,
    input  logic signed [DATA_WIDTH-1:0] amplitude,
    input  logic [LEN_WIDTH-1:0]         length,
    input  logic [DIV_WIDTH-1:0]         rate_div,
    output logic signed [DATA_WIDTH-1:0] data_out,
    output logic                         data_valid,
    input  logic                         data_ready,
    output logic                         busy,
    output logic                         done,
    output logic [LEN_WIDTH-1:0]         sample_count
`ifdef FIR_STIM_OVF_MON_EN
   ,input  logic signed [MON_WIDTH-1:0]  mon_in,
    input  logic                         mon_valid,
    output logic                         ovf_flag
`endif
);
    localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    state_e                state;
    logic [2:0]            mode_q;
    logic [DATA_WIDTH-1:0] amp_q;
    logic [DATA_WIDTH-1:0] acc_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [DIV_WIDTH-1:0]  div_q;
    logic [DIV_WIDTH-1:0]  wait_cnt;
    logic                  odd_q;
    logic [15:0]           lfsr;
    logic [15:0]           lfsr_nxt;

    logic                  start_ok;
    logic                  accept;
    logic [LEN_WIDTH-1:0]  count_nxt;
    logic [DATA_WIDTH-1:0] acc_nxt;

    assign start_ok  = (state == ST_IDLE) && start;
    assign accept    = (state == ST_EMIT) && data_ready && !abort;
    assign count_nxt = sample_count + LEN_WIDTH'(1);
    assign acc_nxt   = acc_q + amp_q;

    // Sample value for index n; 'first' marks n==0, 'odd' marks odd n.
    function automatic logic [DATA_WIDTH-1:0] pick(
        input logic [2:0]            m,
        input logic [DATA_WIDTH-1:0] a,
        input logic                  first,
        input logic                  odd,
        input logic [DATA_WIDTH-1:0] acc,
        input logic [15:0]           lf
    );
        logic [DATA_WIDTH-1:0] v;
        v = '0;
        case (m)
            MODE_DC:      v = a;
            MODE_IMPULSE: v = first ? a : '0;
            MODE_STEP:    v = first ? '0 : a;
            MODE_ALT:     v = !odd ? a : ((a == MOST_NEG) ? ~a : -a);
            MODE_NOISE:   v = lf[15 -: DATA_WIDTH];
            MODE_RAMP:    v = acc;
            default:      v = '0;
        endcase
        return v;
    endfunction

    fir_stim_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .load      (start_ok),
        .advance   (accept),
        .state     (lfsr),
        .state_nxt (lfsr_nxt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            data_out     <= '0;
            data_valid   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            sample_count <= '0;
            mode_q       <= MODE_DC;
            amp_q        <= '0;
            acc_q        <= '0;
            len_q        <= '0;
            div_q        <= '0;
            wait_cnt     <= '0;
            odd_q        <= 1'b0;
        end else begin
            done <= 1'b0;
            // Abort outranks a same-cycle acceptance: the sample is not counted.
            if (state != ST_IDLE && abort) begin
                state      <= ST_IDLE;
                data_valid <= 1'b0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: if (start) begin
                        mode_q       <= mode;
                        amp_q        <= amplitude;
                        len_q        <= length;
                        div_q        <= rate_div;
                        sample_count <= '0;
                        acc_q        <= '0;
                        odd_q        <= 1'b0;
                        data_out     <= pick(mode, amplitude, 1'b1, 1'b0, '0, LFSR_SEED);
                        data_valid   <= 1'b1;
                        busy         <= 1'b1;
                        state        <= ST_EMIT;
                    end
                    ST_EMIT: if (data_ready) begin
                        sample_count <= count_nxt;
                        acc_q        <= acc_nxt;
                        odd_q        <= ~odd_q;
                        data_out     <= pick(mode_q, amp_q, 1'b0, ~odd_q, acc_nxt, lfsr_nxt);
                        if (len_q != '0 && count_nxt == len_q) begin
                            state      <= ST_DONE;
                            data_valid <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                        end else if (div_q > DIV_WIDTH'(1)) begin
                            // div-1 idle cycles put sample starts exactly div cycles apart.
                            state      <= ST_WAIT;
                            data_valid <= 1'b0;
                            wait_cnt   <= div_q - DIV_WIDTH'(2);
                        end
                    end
                    ST_WAIT: begin
                        if (wait_cnt == '0) begin
                            state      <= ST_EMIT;
                            data_valid <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt - DIV_WIDTH'(1);
                        end
                    end
                    ST_DONE: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef FIR_STIM_OVF_MON_EN
    logic [MON_GUARD:0] guard_bits;
    logic               ovf_hit;

    assign guard_bits = mon_in[MON_WIDTH-1 -: MON_GUARD+1];
    assign ovf_hit    = mon_valid && !((&guard_bits) || !(|guard_bits));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          ovf_flag <= 1'b0;
        else if (ovf_hit)  ovf_flag <= 1'b1;
        else if (start_ok) ovf_flag <= 1'b0;
    end
`endif
endmodule

// File: tb/tb_fir_stim_gen.sv
// Scoreboard bench for fir_stim_gen: directed runs push expected samples, a negedge monitor pops on handshake.
module tb_fir_stim_gen;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [2:0]  mode = 3'd0;
    logic [15:0] amplitude = 16'h0;
    logic [15:0] length = 16'h0;
    logic [15:0] rate_div = 16'h0;
    logic        data_ready = 1'b0;
    logic [15:0] data_out;
    logic        data_valid;
    logic        busy;
    logic        done;
    logic [15:0] sample_count;
`ifdef FIR_STIM_OVF_MON_EN
    logic [31:0] mon_in = 32'h0;
    logic        mon_valid = 1'b0;
    logic        ovf_flag;
`endif

    fir_stim_gen dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .mode         (mode),
        .amplitude    (amplitude),
        .length       (length),
        .rate_div     (rate_div),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .busy         (busy),
        .done         (done),
        .sample_count (sample_count)
`ifdef FIR_STIM_OVF_MON_EN
       ,.mon_in       (mon_in),
        .mon_valid    (mon_valid),
        .ovf_flag     (ovf_flag)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] exp_q[$];
    bit          mon_en = 1'b1;
    int          exp_gap = 0;
    int          run_accs = 0;
    int          first_acc = 0;
    int          last_acc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted sample, checks stall stability and pacing.
    initial begin
        bit          prev_valid;
        bit          hold_pending;
        logic [15:0] held;
        prev_valid   = 1'b0;
        hold_pending = 1'b0;
        held         = 16'h0;
        forever begin
            @(negedge clk);
            if (rst && mon_en) begin
                if (data_valid && hold_pending)
                    check("hold_stable", data_out, held);
                if (data_valid && !prev_valid && exp_gap != 0 && run_accs > 0)
                    check("valid_spacing", cyc - last_acc, exp_gap);
                hold_pending = 1'b0;
                if (data_valid && data_ready && !abort) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_sample: got %h, expected none", data_out);
                    end else begin
                        check("sample", data_out, exp_q.pop_front());
                    end
                    if (run_accs == 0) first_acc = cyc;
                    last_acc = cyc;
                    run_accs++;
                end else if (data_valid) begin
                    hold_pending = 1'b1;
                    held         = data_out;
                end
            end
            prev_valid = data_valid;
        end
    end

    task automatic run(input logic [2:0] m, input logic [15:0] amp, input logic [15:0] len, input logic [15:0] div);
        @(posedge clk); #1;
        mode = m; amplitude = amp; length = len; rate_div = div; start = 1'b1;
        run_accs = 0;
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble the run inputs: they were latched and must no longer matter.
        mode = 3'd7; amplitude = 16'h5A5A; length = 16'd1; rate_div = 16'd9;
        check("first_valid_latency", data_valid, 1'b1);
        check("busy_in_run", busy, 1'b1);
    endtask

    task automatic wait_done(input int cnt, input int span);
        int k;
        k = 0;
        @(negedge clk);
        while (done !== 1'b1 && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: no done pulse within 300 cycles");
        end else begin
            check("done_after_last", cyc - last_acc, 1);
            check("final_count", sample_count, cnt);
            check("busy_at_done", busy, 1'b0);
            check("valid_at_done", data_valid, 1'b0);
            if (span >= 0) check("accept_span", last_acc - first_acc, span);
            check("sb_drained", exp_q.size(), 0);
            @(negedge clk);
            check("done_one_cycle", done, 1'b0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k;
        bit  done_seen;

        #2;
        check("rst_data_out", data_out, 16'h0);
        check("rst_valid", data_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_count", sample_count, 16'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        data_ready = 1'b1;

        // DC at max amplitude, back-to-back.
        repeat (4) exp_q.push_back(16'h7FFF);
        run(3'd0, 16'h7FFF, 16'd4, 16'd0);
        wait_done(4, 3);

        // Alternating with saturating negation of the most-negative value.
        exp_q.push_back(16'h8000); exp_q.push_back(16'h7FFF);
        exp_q.push_back(16'h8000); exp_q.push_back(16'h7FFF);
        run(3'd3, 16'h8000, 16'd4, 16'd0);
        wait_done(4, 3);

        // Ramp with rate_div=4 and a two-cycle stall on the second sample.
        exp_q.push_back(16'd0); exp_q.push_back(16'd3); exp_q.push_back(16'd6);
        exp_gap = 4;
        run(3'd5, 16'd3, 16'd3, 16'd4);
        k = 0;
        while (!(data_valid && sample_count == 16'd1) && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL second_sample_timeout: sample 2 never presented");
        end
        data_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        data_ready = 1'b1;
        wait_done(3, 10);
        exp_gap = 0;

        // Noise: seed first, then two Galois steps.
        exp_q.push_back(16'hACE1); exp_q.push_back(16'hE270); exp_q.push_back(16'h7138);
        run(3'd4, 16'h0, 16'd3, 16'd0);
        wait_done(3, 2);

        // Continuous run aborted after three accepted samples.
        repeat (3) exp_q.push_back(16'd5);
        run(3'd0, 16'd5, 16'd0, 16'd0);
        k = 0;
        while (sample_count != 16'd3 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_valid", data_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_count_frozen", sample_count, 16'd3);
        done_seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        check("abort_no_done", done_seen, 1'b0);
        check("abort_sb_drained", exp_q.size(), 0);

        // Restart in impulse mode with a negative amplitude.
        exp_q.push_back(16'hFFF9); exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
        run(3'd1, 16'hFFF9, 16'd3, 16'd0);
        wait_done(3, 2);

        // Asynchronous reset in the middle of EMIT.
        mon_en = 1'b0;
        run(3'd0, 16'h1234, 16'd0, 16'd0);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("arst_data_out", data_out, 16'h0);
        check("arst_valid", data_valid, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        check("arst_count", sample_count, 16'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        mon_en = 1'b1;

`ifdef FIR_STIM_OVF_MON_EN
        mon_in = 32'h3FFF_FFFF; mon_valid = 1'b1;
        @(posedge clk); #1;
        mon_in = 32'hC000_0000;
        @(posedge clk); #1;
        mon_valid = 1'b0;
        check("ovf_in_range", ovf_flag, 1'b0);
        mon_in = 32'h4000_0000; mon_valid = 1'b1;
        @(posedge clk); #1;
        mon_valid = 1'b0; mon_in = 32'h0;
        check("ovf_set", ovf_flag, 1'b1);
        @(posedge clk); #1;
        check("ovf_sticky", ovf_flag, 1'b1);
        exp_q.push_back(16'h0);
        run(3'd6, 16'h1111, 16'd1, 16'd0);
        check("ovf_cleared_by_start", ovf_flag, 1'b0);
        wait_done(1, 0);
        mon_in = 32'h8000_0000; mon_valid = 1'b1;
        exp_q.push_back(16'h0);
        run(3'd7, 16'h2222, 16'd1, 16'd0);
        mon_valid = 1'b0;
        check("ovf_set_beats_start", ovf_flag, 1'b1);
        wait_done(1, 0);
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
